// File: rtl/llr_user_sched_ctrl.sv
// llr_user_sched_ctrl: per-user sequencer in front of the slow PHY-to-LLR sender.
// Queues user descriptors, drives the sender's static config, pulses its FSM
// reset before each user, counts IQ FIFO reads (4 REs each) to detect
// completion, and reports each finished user upstream.
// Ports: i_core_clk/i_rx_rst (async active-high); i_enable gates new users;
//   i_desc_* / o_desc_ready = descriptor push; o_rx_fsm_rstn and
//   o_user_iq_noise_rate / o_cur_user_re_amounts = sender control/config;
//   i_iq_fifo_rd_en / i_data_strobe = monitored sender activity;
//   o_busy, o_user_done, o_done_user_id, o_done_re_count, o_user_skip = status.
// Optional build macro LLR_SCHED_TIMEOUT_EN: adds a RUN/DRAIN inactivity
//   timeout and the o_err_timeout output (pulses with o_user_done).
module llr_user_sched_ctrl #(
   parameter int DESC_DEPTH     = 4,
   parameter int RST_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        i_core_clk,
   input  logic        i_rx_rst,
   input  logic        i_enable,
   input  logic        i_desc_valid,
   output logic        o_desc_ready,
   input  logic [15:0] i_desc_re_amounts,
   input  logic [15:0] i_desc_iq_noise_rate,
   input  logic [7:0]  i_desc_user_id,
   output logic        o_rx_fsm_rstn,
   output logic [15:0] o_user_iq_noise_rate,
   output logic [15:0] o_cur_user_re_amounts,
   input  logic        i_iq_fifo_rd_en,
   input  logic        i_data_strobe,
   output logic        o_busy,
   output logic        o_user_done,
   output logic [7:0]  o_done_user_id,
   output logic [15:0] o_done_re_count,
   output logic        o_user_skip
`ifdef LLR_SCHED_TIMEOUT_EN
   ,
   output logic        o_err_timeout
`endif
);

   localparam int AW = $clog2(DESC_DEPTH);
   localparam int RW = $clog2(RST_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RST,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [15:0] q_re   [DESC_DEPTH];
   logic [15:0] q_rate [DESC_DEPTH];
   logic [7:0]  q_id   [DESC_DEPTH];

   logic [AW:0]   wr_ptr, rd_ptr;
   logic          full, empty, push, pop;
   logic [15:0]   head_re, head_rate;
   logic [7:0]    head_id;
   logic          head_skip;
   logic [RW-1:0] rst_cnt;
   logic [15:0]   re_cnt, cnt_inc, cnt_nx;
   logic [16:0]   cnt_sum;
   logic [7:0]    cur_id;
   logic          skip_q;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // Ready is forced low while reset is held so every output reads 0.
   assign o_desc_ready = ~full & ~i_rx_rst;
   assign push         = i_desc_valid & o_desc_ready;
   assign pop          = (state == S_LOAD);

   assign head_re   = q_re[rd_ptr[AW-1:0]];
   assign head_rate = q_rate[rd_ptr[AW-1:0]];
   assign head_id   = q_id[rd_ptr[AW-1:0]];
   assign head_skip = (head_re == 16'd0) | (head_rate == 16'd0);

   always_ff @(posedge i_core_clk) begin
      if (push) begin
         q_re[wr_ptr[AW-1:0]]   <= i_desc_re_amounts;
         q_rate[wr_ptr[AW-1:0]] <= i_desc_iq_noise_rate;
         q_id[wr_ptr[AW-1:0]]   <= i_desc_user_id;
      end
   end

   always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
      if (i_rx_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Each read delivers 4 REs; the count saturates instead of wrapping.
   assign cnt_sum = {1'b0, re_cnt} + 17'd4;
   assign cnt_inc = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   assign cnt_nx  = ((state == S_RUN) && i_iq_fifo_rd_en) ? cnt_inc : re_cnt;

`ifdef LLR_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;
   logic          tmo_hit, tmo_take, tmo_q;

   assign tmo_hit = ((state == S_RUN) || (state == S_DRAIN)) &&
                    !i_iq_fifo_rd_en &&
                    (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_nx = state;
`ifdef LLR_SCHED_TIMEOUT_EN
      tmo_take = 1'b0;
`endif
      unique case (state)
         S_IDLE:  if (!empty && i_enable) state_nx = S_LOAD;
         S_LOAD:  state_nx = head_skip ? S_DONE : S_RST;
         S_RST:   if (rst_cnt == RW'(RST_CYCLES - 1)) state_nx = S_RUN;
         S_RUN:   if (cnt_nx >= o_cur_user_re_amounts) state_nx = S_DRAIN;
         S_DRAIN: if (!i_data_strobe) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
`ifdef LLR_SCHED_TIMEOUT_EN
      // Timeout only wins when the normal flow would stay put.
      if (tmo_hit && (state_nx == state)) begin
         tmo_take = 1'b1;
         state_nx = S_DONE;
      end
`endif
   end

   always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
      if (i_rx_rst) begin
         state                 <= S_IDLE;
         rst_cnt               <= '0;
         re_cnt                <= '0;
         cur_id                <= '0;
         skip_q                <= 1'b0;
         o_user_iq_noise_rate  <= '0;
         o_cur_user_re_amounts <= '0;
      end else begin
         state <= state_nx;
         if (state == S_LOAD) begin
            o_user_iq_noise_rate  <= head_rate;
            o_cur_user_re_amounts <= head_re;
            cur_id                <= head_id;
            skip_q                <= head_skip;
            re_cnt                <= '0;
            rst_cnt               <= '0;
         end else begin
            re_cnt <= cnt_nx;
            if (state == S_RST) rst_cnt <= rst_cnt + 1'b1;
         end
      end
   end

`ifdef LLR_SCHED_TIMEOUT_EN
   // Idle counter restarts on every read and on every state change.
   always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
      if (i_rx_rst) begin
         idle_cnt <= '0;
         tmo_q    <= 1'b0;
      end else begin
         if ((state_nx != state) || i_iq_fifo_rd_en)
            idle_cnt <= '0;
         else if ((state == S_RUN) || (state == S_DRAIN))
            idle_cnt <= idle_cnt + 1'b1;
         if (tmo_take)
            tmo_q <= 1'b1;
         else if (state == S_LOAD)
            tmo_q <= 1'b0;
      end
   end

   assign o_err_timeout = o_user_done & tmo_q;
`endif

   assign o_rx_fsm_rstn   = (state == S_RUN) || (state == S_DRAIN);
   assign o_busy          = (state != S_IDLE);
   assign o_user_done     = (state == S_DONE);
   assign o_done_user_id  = o_user_done ? cur_id : 8'd0;
   assign o_done_re_count = o_user_done ? re_cnt : 16'd0;
   assign o_user_skip     = o_user_done & skip_q;

endmodule

// File: tb/tb_llr_user_sched_ctrl.sv
// tb_llr_user_sched_ctrl: directed bench for llr_user_sched_ctrl.
// User-timeline model checked every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_llr_user_sched_ctrl;

   localparam int DEPTH = 4;
   localparam int RSTC  = 2;
`ifdef LLR_SCHED_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 4096;
`endif

   logic clk = 0, rst = 0, en = 0, dv = 0, rd = 0, stb = 0;
   logic [15:0] d_re = 0, d_rate = 0;
   logic [7:0]  d_id = 0;
   logic ready, rstn, busy, done, skip;
   logic [15:0] cfg_rate, cfg_re, dcnt;
   logic [7:0]  did;
`ifdef LLR_SCHED_TIMEOUT_EN
   logic tmo_o;
`endif

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   llr_user_sched_ctrl #(
      .DESC_DEPTH(DEPTH), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_core_clk(clk),
      .i_rx_rst(rst),
      .i_enable(en),
      .i_desc_valid(dv),
      .o_desc_ready(ready),
      .i_desc_re_amounts(d_re),
      .i_desc_iq_noise_rate(d_rate),
      .i_desc_user_id(d_id),
      .o_rx_fsm_rstn(rstn),
      .o_user_iq_noise_rate(cfg_rate),
      .o_cur_user_re_amounts(cfg_re),
      .i_iq_fifo_rd_en(rd),
      .i_data_strobe(stb),
      .o_busy(busy),
      .o_user_done(done),
      .o_done_user_id(did),
      .o_done_re_count(dcnt),
      .o_user_skip(skip)
`ifdef LLR_SCHED_TIMEOUT_EN
      ,
      .o_err_timeout(tmo_o)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- user-timeline model ----------------
   typedef struct packed {
      logic [15:0] re;
      logic [15:0] rate;
      logic [7:0]  id;
   } desc_t;

   desc_t mq[$];
   desc_t cur = '0;
   bit    m_act = 0, m_skip = 0, m_reach = 0, m_tmo = 0;
   int    m_age = 0, m_done_age = -1, m_cnt = 0, m_idle = 0;
   logic [15:0] m_cfg_re = 0, m_cfg_rate = 0;

   task automatic tmo_step();
`ifdef LLR_SCHED_TIMEOUT_EN
      if (m_idle == TMO - 1) begin
         m_done_age = m_age + 1;
         m_tmo = 1;
      end else m_idle++;
`endif
   endtask

   initial begin
      bit rdy;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            m_act = 0; m_skip = 0; m_reach = 0; m_tmo = 0;
            m_age = 0; m_done_age = -1; m_cnt = 0; m_idle = 0;
            m_cfg_re = 0; m_cfg_rate = 0;
         end else begin
            rdy = (mq.size() < DEPTH);
            if (!m_act) begin
               if (mq.size() > 0 && en) begin
                  cur = mq[0];
                  m_act = 1; m_age = 0; m_cnt = 0;
                  m_reach = 0; m_tmo = 0; m_idle = 0;
                  m_skip = (cur.re == 0) || (cur.rate == 0);
                  m_done_age = m_skip ? 1 : -1;
               end
            end else if (m_age == m_done_age) begin
               m_act = 0;
            end else begin
               if (m_age == 0) begin
                  void'(mq.pop_front());
                  m_cfg_re = cur.re;
                  m_cfg_rate = cur.rate;
               end else if (!m_skip && m_age > RSTC) begin
                  if (!m_reach) begin
                     if (rd) begin
                        m_cnt = (m_cnt + 4 > 65535) ? 65535 : m_cnt + 4;
                        m_idle = 0;
                        if (m_cnt >= cur.re) m_reach = 1;
                     end else tmo_step();
                  end else if (!stb) m_done_age = m_age + 1;
                  else if (rd) m_idle = 0;
                  else tmo_step();
               end
               m_age++;
            end
            if (dv && rdy)
               mq.push_back('{re: d_re, rate: d_rate, id: d_id});
         end
      end
   end

   // ---------------- compare + event log ----------------
   int lg_id[$], lg_cnt[$], lg_skip[$], lg_cyc[$], lg_tmo[$];
   int busy_rise[$], rstn_rise[$];
   int cyc = 0;
   logic p_busy = 0, p_rstn = 0;

   always @(negedge clk) begin
      bit ed, er;
      cyc++;
      if (!rst) begin
         ed = m_act && (m_age == m_done_age);
         er = m_act && !m_skip && (m_age > RSTC) &&
              ((m_done_age < 0) || (m_age < m_done_age));
         chk("ready", ready, mq.size() < DEPTH);
         chk("busy", busy, m_act);
         chk("rstn", rstn, er);
         chk("done", done, ed);
         chk("done_id", did, ed ? cur.id : 0);
         chk("done_cnt", dcnt, ed ? m_cnt : 0);
         chk("skip", skip, ed && m_skip);
         chk("cfg_re", cfg_re, m_cfg_re);
         chk("cfg_rate", cfg_rate, m_cfg_rate);
`ifdef LLR_SCHED_TIMEOUT_EN
         chk("err_timeout", tmo_o, ed && m_tmo);
`endif
         if (done) begin
            lg_id.push_back(did);
            lg_cnt.push_back(dcnt);
            lg_skip.push_back(skip);
            lg_cyc.push_back(cyc);
`ifdef LLR_SCHED_TIMEOUT_EN
            lg_tmo.push_back(tmo_o);
`else
            lg_tmo.push_back(0);
`endif
         end
         if (busy && !p_busy) busy_rise.push_back(cyc);
         if (rstn && !p_rstn) rstn_rise.push_back(cyc);
      end
      p_busy = busy;
      p_rstn = rstn;
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] re, input logic [15:0] rate,
                       input logic [7:0] id);
      d_re = re; d_rate = rate; d_id = id; dv = 1;
      tick();
      dv = 0;
   endtask

   task automatic wait_rstn(input logic lvl);
      int k = 0;
      while (rstn !== lvl && k < 200) begin
         tick();
         k++;
      end
      chk("wait_rstn", rstn, lvl);
   endtask

   task automatic wait_done(input int n, input int budget);
      int k = 0;
      while (lg_id.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("wait_done", lg_id.size() >= n, 1);
   endtask

   // Sender stand-in: n reads every per cycles, strobe lags one cycle.
   task automatic send(input int per, input int n);
      wait_rstn(0);
      wait_rstn(1);
      stb = 1;
      for (int i = 0; i < n; i++) begin
         rd = 1;
         tick();
         rd = 0;
         if (i < n - 1) tick(per - 1);
      end
      tick();
      stb = 0;
   endtask

   initial begin
      #1 rst = 1;
      #2;
      chk("rst_ready", ready, 0);
      chk("rst_rstn", rstn, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_re", cfg_re, 0);
      tick(2);
      rst = 0;
      #1 chk("ready_after_rst", ready, 1);

      // one user, reads every 2 cycles
      en = 1;
      push(16, 2, 5);
      send(2, 4);
      wait_done(1, 50);
      chk("t1_id", lg_id[0], 5);
      chk("t1_cnt", lg_cnt[0], 16);
      chk("t1_skip", lg_skip[0], 0);
      chk("t1_load_to_run", rstn_rise[0] - busy_rise[0], 1 + RSTC);
      tick(2);

      // fill queue while disabled, 5th push dropped
      en = 0;
      for (int i = 1; i <= 4; i++) push(8, 1, 8'(i));
      chk("full_ready", ready, 0);
      push(8, 1, 99);
      chk("idle_while_disabled", busy, 0);
      en = 1;
      for (int i = 0; i < 4; i++) send(1, 2);
      wait_done(5, 50);
      for (int i = 1; i <= 4; i++) chk("order_id", lg_id[i], i);
      chk("rstn_pulses", rstn_rise.size(), 5);
      tick(6);
      chk("drop_no_extra_user", busy, 0);

      // degenerate descriptor
      push(16, 0, 9);
      wait_done(6, 20);
      chk("skip_id", lg_id[5], 9);
      chk("skip_flag", lg_skip[5], 1);
      chk("skip_cnt", lg_cnt[5], 0);
      chk("skip_latency", lg_cyc[5] - busy_rise[5], 1);
      chk("skip_no_rstn", rstn_rise.size(), 5);
      tick(2);

      // async reset mid-RUN with 2 queued
      push(100, 1, 20);
      push(100, 1, 21);
      push(100, 1, 22);
      wait_rstn(1);
      rd = 1;
      tick(2);
      rd = 0;
      #2 rst = 1;
      #1;
      chk("amid_rstn", rstn, 0);
      chk("amid_busy", busy, 0);
      chk("amid_ready", ready, 0);
      chk("amid_cfg_re", cfg_re, 0);
      chk("amid_cfg_rate", cfg_rate, 0);
      tick();
      rst = 0;
      tick(20);
      chk("after_rst_no_done", lg_id.size(), 6);
      chk("after_rst_idle", busy, 0);

      // count rounding and saturation
      push(10, 1, 30);
      send(1, 3);
      wait_done(7, 50);
      chk("r10_cnt", lg_cnt[6], 12);
      tick(2);
      push(16'hFFFF, 1, 31);
      send(1, 20000);
      wait_done(8, 200);
      chk("sat_cnt", lg_cnt[7], 16'hFFFF);
      chk("sat_id", lg_id[7], 31);
      tick(2);

`ifdef LLR_SCHED_TIMEOUT_EN
      push(100, 1, 40);
      send(2, 2);
      wait_done(9, 100);
      chk("tmo_flag", lg_tmo[8], 1);
      chk("tmo_cnt", lg_cnt[8], 8);
      tick(2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
